// File: rtl/ethernet_hub_pkg.sv
// Shared AXI-Stream hub definitions: stream data width, constant clog2 and the
// packet arbiter state encoding, reused by the MAC hub wrappers.
package ethernet_hub_pkg;

  localparam int AXIS_DW = 8;

  typedef enum logic [1:0] {
    IDLE,
    XFER,
    FLUSH
  } arb_state_t;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

endpackage

// File: rtl/rr_priority_select.sv
// Rotate-priority encoder: returns the first asserted req at or after ptr, wrapping
// NUM_REQ-1 -> 0. Purely combinational, no backpressure of its own.
module rr_priority_select #(
  parameter int NUM_REQ = 4,
  parameter int IDXW    = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDXW-1:0]    ptr,
  output logic               any,
  output logic [IDXW-1:0]    idx
);

  logic [NUM_REQ-1:0] req_rot;
  logic [IDXW:0]      cand;

  assign req_rot = NUM_REQ'({req, req} >> ptr);

  always_comb begin
    any  = 1'b0;
    idx  = '0;
    cand = '0;
    // Walk from the farthest offset down so the nearest requester is written last.
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (req_rot[k]) begin
        cand = {1'b0, ptr} + (IDXW+1)'(k);
        if (cand >= (IDXW+1)'(NUM_REQ)) cand = cand - (IDXW+1)'(NUM_REQ);
        any = 1'b1;
        idx = cand[IDXW-1:0];
      end
    end
  end

endmodule

// File: rtl/axis_packet_rr_arbiter.sv
// Packet-atomic round-robin merge of NUM_REQ AXI-Stream sources: 1 idle cycle per packet
// for arbitration, then 0-cycle pass-through with m_axis_tready routed to the granted source.
module axis_packet_rr_arbiter
  import ethernet_hub_pkg::*;
#(
  parameter int NUM_REQ     = 4,
  parameter int MAX_PKT_LEN = 1472,
  parameter int IDXW        = 3
) (
  input  logic                       axis_aclk,
  input  logic                       axis_aresetn,
  input  logic [NUM_REQ*AXIS_DW-1:0] s_axis_tdata,
  input  logic [NUM_REQ-1:0]         s_axis_tvalid,
  input  logic [NUM_REQ-1:0]         s_axis_tlast,
  output logic [NUM_REQ-1:0]         s_axis_tready,
  output logic [AXIS_DW-1:0]         m_axis_tdata,
  output logic                       m_axis_tvalid,
  output logic                       m_axis_tlast,
  input  logic                       m_axis_tready,
  output logic [IDXW-1:0]            m_axis_tdest,
  output logic                       trunc_pulse
);

  localparam int              CNTW     = clog2(MAX_PKT_LEN + 1);
  localparam logic [CNTW-1:0] LAST_CNT = CNTW'(MAX_PKT_LEN - 1);
  localparam logic [IDXW-1:0] TOP_IDX  = IDXW'(NUM_REQ - 1);

  arb_state_t         state, state_nxt;
  logic [IDXW-1:0]    rr_ptr, rr_ptr_nxt;
  logic [IDXW-1:0]    grant, grant_nxt, grant_inc;
  logic [CNTW-1:0]    beat_cnt, beat_cnt_nxt;
  logic               trunc_nxt;
  logic               req_any;
  logic [IDXW-1:0]    req_idx;
  logic [AXIS_DW-1:0] sel_dat;
  logic               sel_vld;
  logic               sel_lst;
  logic               at_limit;
  logic               beat;

  rr_priority_select #(
    .NUM_REQ(NUM_REQ),
    .IDXW   (IDXW)
  ) u_sel (
    .req(s_axis_tvalid),
    .ptr(rr_ptr),
    .any(req_any),
    .idx(req_idx)
  );

  always_comb begin : src_mux
    sel_dat = '0;
    sel_vld = 1'b0;
    sel_lst = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (grant == IDXW'(k)) begin
        sel_dat = s_axis_tdata[AXIS_DW*k +: AXIS_DW];
        sel_vld = s_axis_tvalid[k];
        sel_lst = s_axis_tlast[k];
      end
    end
  end

  assign grant_inc = (grant == TOP_IDX) ? '0 : grant + IDXW'(1);
  assign at_limit  = (beat_cnt == LAST_CNT);

  always_ff @(posedge axis_aclk or negedge axis_aresetn) begin
    if (!axis_aresetn) begin
      state       <= IDLE;
      rr_ptr      <= '0;
      grant       <= '0;
      beat_cnt    <= '0;
      trunc_pulse <= 1'b0;
    end else begin
      state       <= state_nxt;
      rr_ptr      <= rr_ptr_nxt;
      grant       <= grant_nxt;
      beat_cnt    <= beat_cnt_nxt;
      trunc_pulse <= trunc_nxt;
    end
  end

  always_comb begin : fsm
    state_nxt     = state;
    rr_ptr_nxt    = rr_ptr;
    grant_nxt     = grant;
    beat_cnt_nxt  = beat_cnt;
    trunc_nxt     = 1'b0;
    beat          = 1'b0;
    m_axis_tdata  = '0;
    m_axis_tvalid = 1'b0;
    m_axis_tlast  = 1'b0;
    m_axis_tdest  = '0;
    s_axis_tready = '0;
    case (state)
      IDLE: begin
        if (req_any) begin
          grant_nxt    = req_idx;
          beat_cnt_nxt = '0;
          state_nxt    = XFER;
        end
      end
      XFER: begin
        m_axis_tdata  = sel_dat;
        m_axis_tvalid = sel_vld;
        // The beat at the length limit closes the packet even without a source tlast.
        m_axis_tlast  = sel_vld & (sel_lst | at_limit);
        m_axis_tdest  = grant;
        for (int k = 0; k < NUM_REQ; k++) begin
          s_axis_tready[k] = (grant == IDXW'(k)) & m_axis_tready;
        end
        beat = sel_vld & m_axis_tready;
        if (beat) begin
          beat_cnt_nxt = beat_cnt + CNTW'(1);
          if (sel_lst) begin
            state_nxt  = IDLE;
            rr_ptr_nxt = grant_inc;
          end else if (at_limit) begin
            state_nxt = FLUSH;
            trunc_nxt = 1'b1;
          end
        end
      end
      FLUSH: begin
        for (int k = 0; k < NUM_REQ; k++) begin
          s_axis_tready[k] = (grant == IDXW'(k));
        end
        if (sel_vld & sel_lst) begin
          state_nxt  = IDLE;
          rr_ptr_nxt = grant_inc;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_axis_packet_rr_arbiter.sv
// Bench for axis_packet_rr_arbiter: per-cycle vector table, directed corner sequences and a
// randomized run checked by a per-source packet scoreboard.
`timescale 1ns/1ps
module tb_axis_packet_rr_arbiter;

  localparam int NR   = 4;
  localparam int MAXL = 8;
  localparam int IW   = 2;

  logic            axis_aclk = 1'b0;
  logic            axis_aresetn;
  logic [NR*8-1:0] s_axis_tdata;
  logic [NR-1:0]   s_axis_tvalid;
  logic [NR-1:0]   s_axis_tlast;
  logic [NR-1:0]   s_axis_tready;
  logic [7:0]      m_axis_tdata;
  logic            m_axis_tvalid;
  logic            m_axis_tlast;
  logic            m_axis_tready;
  logic [IW-1:0]   m_axis_tdest;
  logic            trunc_pulse;

  always #5 axis_aclk = ~axis_aclk;

  axis_packet_rr_arbiter #(
    .NUM_REQ    (NR),
    .MAX_PKT_LEN(MAXL),
    .IDXW       (IW)
  ) dut (
    .axis_aclk    (axis_aclk),
    .axis_aresetn (axis_aresetn),
    .s_axis_tdata (s_axis_tdata),
    .s_axis_tvalid(s_axis_tvalid),
    .s_axis_tlast (s_axis_tlast),
    .s_axis_tready(s_axis_tready),
    .m_axis_tdata (m_axis_tdata),
    .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tlast (m_axis_tlast),
    .m_axis_tready(m_axis_tready),
    .m_axis_tdest (m_axis_tdest),
    .trunc_pulse  (trunc_pulse)
  );

  typedef struct packed {
    logic [7:0] dat;
    logic       last;
  } beat_t;

  typedef struct packed {
    logic          rdy;
    logic          vld;
    logic [IW-1:0] dest;
    logic [7:0]    dat;
    logic          last;
    logic [NR-1:0] trdy;
  } vec_t;

  beat_t src_q [NR][$];
  beat_t exp_q [NR][$];
  int    pkt_order[$];
  vec_t  vt [18];

  int            n_vec, n_err;
  int            n_trunc_seen, n_trunc_exp, n_beats;
  int            bubble_pct;
  logic          in_pkt, prev_last;
  logic [IW-1:0] cur_dest;
  logic [NR-1:0] hs;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  function automatic vec_t mkv(input logic rdy, input logic vld, input logic [IW-1:0] dest,
                               input logic [7:0] dat, input logic last, input logic [NR-1:0] trdy);
    vec_t v;
    v.rdy = rdy; v.vld = vld; v.dest = dest; v.dat = dat; v.last = last; v.trdy = trdy;
    return v;
  endfunction

  // Queue one packet; the expected output is its first MAXL beats, closed at the limit.
  task automatic add_pkt(input int src, input int len, input int base);
    beat_t b;
    for (int k = 0; k < len; k++) begin
      b.dat  = (base < 0) ? 8'($urandom) : 8'(base + k);
      b.last = (k == len - 1);
      src_q[src].push_back(b);
      if (k < MAXL) begin
        b.last = (k == len - 1) || (k == MAXL - 1);
        exp_q[src].push_back(b);
      end
    end
    if (len > MAXL) n_trunc_exp++;
  endtask

  function automatic bit all_empty();
    for (int i = 0; i < NR; i++)
      if (src_q[i].size() != 0 || exp_q[i].size() != 0) return 1'b0;
    return 1'b1;
  endfunction

  task automatic drive(input logic rdy);
    for (int i = 0; i < NR; i++) begin
      if (hs[i] && src_q[i].size() > 0) void'(src_q[i].pop_front());
      if (src_q[i].size() > 0 && int'($urandom_range(0, 99)) >= bubble_pct) begin
        s_axis_tvalid[i]      = 1'b1;
        s_axis_tdata[8*i +: 8] = src_q[i][0].dat;
        s_axis_tlast[i]       = src_q[i][0].last;
      end else begin
        s_axis_tvalid[i]      = 1'b0;
        s_axis_tdata[8*i +: 8] = 8'h00;
        s_axis_tlast[i]       = 1'b0;
      end
    end
    m_axis_tready = rdy;
  endtask

  task automatic sample();
    beat_t e;
    hs = s_axis_tvalid & s_axis_tready;
    if (trunc_pulse) begin
      n_trunc_seen++;
      chk("trunc_pulse_after_last_beat", 32'(prev_last), 32'd1);
    end
    prev_last = 1'b0;
    if (m_axis_tvalid && m_axis_tready) begin
      n_beats++;
      if (in_pkt) chk("no_interleave_dest", 32'(m_axis_tdest), 32'(cur_dest));
      if (exp_q[m_axis_tdest].size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL spurious_beat: src %0d gave data %h, expected no beat", m_axis_tdest, m_axis_tdata);
      end else begin
        e = exp_q[m_axis_tdest].pop_front();
        chk($sformatf("beat_src%0d", m_axis_tdest), 32'({m_axis_tdata, m_axis_tlast}), 32'({e.dat, e.last}));
      end
      in_pkt    = !m_axis_tlast;
      cur_dest  = m_axis_tdest;
      prev_last = m_axis_tlast;
      if (m_axis_tlast) pkt_order.push_back(int'(m_axis_tdest));
    end
  endtask

  task automatic cycle(input logic rdy);
    @(posedge axis_aclk);
    #1;
    drive(rdy);
    @(negedge axis_aclk);
    sample();
  endtask

  task automatic drain(input int budget, input int rpct);
    int c;
    c = 0;
    while (!all_empty() && c < budget) begin
      cycle(int'($urandom_range(0, 99)) < rpct);
      c++;
    end
    if (!all_empty()) begin
      n_vec++;
      n_err++;
      $display("FAIL drain_timeout: %0d cycles used, traffic still pending", c);
    end
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int nb, c;
    n_vec = 0; n_err = 0; n_trunc_seen = 0; n_trunc_exp = 0; n_beats = 0;
    bubble_pct = 0; in_pkt = 1'b0; prev_last = 1'b0; cur_dest = '0; hs = '0;

    vt[0]  = mkv(1'b1, 1'b0, 2'd0, 8'h00, 1'b0, 4'b0000);
    vt[1]  = mkv(1'b1, 1'b1, 2'd0, 8'h00, 1'b0, 4'b0001);
    vt[2]  = mkv(1'b0, 1'b1, 2'd0, 8'h01, 1'b0, 4'b0000);
    vt[3]  = mkv(1'b1, 1'b1, 2'd0, 8'h01, 1'b0, 4'b0001);
    vt[4]  = mkv(1'b1, 1'b1, 2'd0, 8'h02, 1'b1, 4'b0001);
    vt[5]  = mkv(1'b1, 1'b0, 2'd0, 8'h00, 1'b0, 4'b0000);
    vt[6]  = mkv(1'b1, 1'b1, 2'd1, 8'h10, 1'b0, 4'b0010);
    vt[7]  = mkv(1'b1, 1'b1, 2'd1, 8'h11, 1'b0, 4'b0010);
    vt[8]  = mkv(1'b1, 1'b1, 2'd1, 8'h12, 1'b1, 4'b0010);
    vt[9]  = mkv(1'b1, 1'b0, 2'd0, 8'h00, 1'b0, 4'b0000);
    vt[10] = mkv(1'b1, 1'b1, 2'd2, 8'h20, 1'b0, 4'b0100);
    vt[11] = mkv(1'b1, 1'b1, 2'd2, 8'h21, 1'b0, 4'b0100);
    vt[12] = mkv(1'b1, 1'b1, 2'd2, 8'h22, 1'b1, 4'b0100);
    vt[13] = mkv(1'b1, 1'b0, 2'd0, 8'h00, 1'b0, 4'b0000);
    vt[14] = mkv(1'b1, 1'b1, 2'd3, 8'h30, 1'b0, 4'b1000);
    vt[15] = mkv(1'b1, 1'b1, 2'd3, 8'h31, 1'b0, 4'b1000);
    vt[16] = mkv(1'b1, 1'b1, 2'd3, 8'h32, 1'b1, 4'b1000);
    vt[17] = mkv(1'b1, 1'b0, 2'd0, 8'h00, 1'b0, 4'b0000);

    // Reset held with every source requesting.
    axis_aresetn  = 1'b0;
    s_axis_tvalid = '1;
    s_axis_tlast  = '1;
    s_axis_tdata  = '1;
    m_axis_tready = 1'b1;
    repeat (3) begin
      @(negedge axis_aclk);
      chk("reset_outputs", 32'({m_axis_tvalid, m_axis_tlast, m_axis_tdata, m_axis_tdest, trunc_pulse, s_axis_tready}), 32'd0);
    end
    s_axis_tvalid = '0; s_axis_tlast = '0; s_axis_tdata = '0;
    axis_aresetn  = 1'b1;

    // Four simultaneous 3-beat packets, one backpressure cycle inside the first.
    for (int i = 0; i < NR; i++) add_pkt(i, 3, 16 * i);
    for (int r = 0; r < 18; r++) begin
      cycle(vt[r].rdy);
      if (vt[r].vld)
        chk($sformatf("table_row%0d", r),
            32'({m_axis_tvalid, m_axis_tdest, m_axis_tdata, m_axis_tlast, s_axis_tready}),
            32'({vt[r].vld, vt[r].dest, vt[r].dat, vt[r].last, vt[r].trdy}));
      else
        chk($sformatf("table_row%0d_idle", r), 32'({m_axis_tvalid, s_axis_tready}), 32'({vt[r].vld, vt[r].trdy}));
    end

    // Fairness: source 1 gets in between packets of a continuously streaming source 2.
    pkt_order.delete();
    repeat (3) add_pkt(2, 4, -1);
    cycle(1'b1);
    cycle(1'b1);
    add_pkt(1, 2, -1);
    drain(200, 100);
    chk("fair_count", 32'(pkt_order.size()), 32'd4);
    if (pkt_order.size() == 4)
      chk("fair_order", 32'({4'(pkt_order[0]), 4'(pkt_order[1]), 4'(pkt_order[2]), 4'(pkt_order[3])}), 32'h2122);

    // Truncation at MAXL, tlast exactly at MAXL, then a short clean packet.
    pkt_order.delete();
    n_trunc_seen = 0; n_trunc_exp = 0;
    add_pkt(0, 12, -1);
    add_pkt(0, MAXL, -1);
    add_pkt(0, 3, -1);
    drain(200, 100);
    cycle(1'b1);
    cycle(1'b1);
    chk("trunc_pulse_count", 32'(n_trunc_seen), 32'(n_trunc_exp));
    chk("trunc_pkt_count", 32'(pkt_order.size()), 32'd3);

    // Random traffic with source bubbles and sink backpressure.
    n_trunc_seen = 0; n_trunc_exp = 0;
    bubble_pct = 30;
    for (int p = 0; p < 1000; p++) add_pkt(int'($urandom_range(0, NR - 1)), int'($urandom_range(1, MAXL + 3)), -1);
    drain(60000, 50);
    cycle(1'b1);
    cycle(1'b1);
    chk("random_trunc_count", 32'(n_trunc_seen), 32'(n_trunc_exp));
    bubble_pct = 0;

    // Reset in the middle of a packet, with rr_ptr moved off 0 beforehand.
    add_pkt(1, 2, -1);
    drain(100, 100);
    add_pkt(2, 10, -1);
    nb = n_beats;
    c  = 0;
    while (n_beats - nb < 5 && c < 40) begin
      cycle(1'b1);
      c++;
    end
    if (n_beats - nb < 5) begin
      n_vec++;
      n_err++;
      $display("FAIL midpkt_wait: %0d beats seen, expected 5", n_beats - nb);
    end
    chk("pre_reset_valid", 32'(m_axis_tvalid), 32'd1);
    #1 axis_aresetn = 1'b0;
    #1;
    chk("reset_drops_valid", 32'({m_axis_tvalid, s_axis_tready}), 32'd0);
    for (int i = 0; i < NR; i++) begin
      src_q[i].delete();
      exp_q[i].delete();
    end
    s_axis_tvalid = '0; s_axis_tlast = '0; s_axis_tdata = '0;
    hs = '0; in_pkt = 1'b0; prev_last = 1'b0;
    repeat (2) @(negedge axis_aclk);
    axis_aresetn = 1'b1;
    cycle(1'b1);
    chk("post_reset_idle", 32'({m_axis_tvalid, m_axis_tlast, m_axis_tdest, s_axis_tready}), 32'd0);
    pkt_order.delete();
    add_pkt(3, 2, -1);
    add_pkt(0, 2, -1);
    drain(100, 100);
    chk("post_reset_count", 32'(pkt_order.size()), 32'd2);
    if (pkt_order.size() == 2)
      chk("post_reset_order", 32'({4'(pkt_order[0]), 4'(pkt_order[1])}), 32'h03);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
